// File: rtl/tl_rx_write_handler_cpl_control.sv
// Receive-side completion write handler: steers header/data beats of incoming
// completion TLPs into the VC completion buffers and flags framing/length errors.
module tl_rx_write_handler_cpl_control #(
  parameter int PAYLOAD_LENGTH   = 10,
  parameter int VALID_DATA_WIDTH = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tlp_valid,
  input  logic                        i_tlp_sop,
  input  logic                        i_tlp_eop,
  input  logic                        i_cpl_fmt_data_bit,
  input  logic [PAYLOAD_LENGTH-1:0]   i_cpl_length_field,
  output logic                        o_tlp_ready,
  input  logic [1:0]                  i_vcn_cpl_w_full_flags,
  output logic                        o_cpl_hdr_wr_en,
  output logic                        o_cpl_data_wr_en,
  output logic [VALID_DATA_WIDTH-1:0] o_cpl_data_valid_dw,
  output logic                        o_cpl_received,
  output logic                        o_cpl_malformed
);

  localparam int CW = PAYLOAD_LENGTH + 1;
  localparam logic [CW-1:0] BEAT_DW = CW'(32);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_remaining, w_remaining_nxt;
  logic            r_received, r_malformed;
  logic            w_received_nxt, w_malformed_nxt;
  logic            w_hs;
  logic            w_last_beat;

  always_comb begin
    o_tlp_ready = 1'b0;
    if (!i_rst) begin
      case (r_state)
        IDLE:    o_tlp_ready = ~i_vcn_cpl_w_full_flags[0];
        DATA:    o_tlp_ready = ~i_vcn_cpl_w_full_flags[1];
        DROP:    o_tlp_ready = 1'b1;
        default: o_tlp_ready = 1'b0;
      endcase
    end
  end

  assign w_hs        = i_tlp_valid & o_tlp_ready;
  assign w_last_beat = (r_remaining <= BEAT_DW);

  always_comb begin
    w_state_nxt         = r_state;
    w_remaining_nxt     = r_remaining;
    w_received_nxt      = 1'b0;
    w_malformed_nxt     = 1'b0;
    o_cpl_hdr_wr_en     = 1'b0;
    o_cpl_data_wr_en    = 1'b0;
    o_cpl_data_valid_dw = '0;
    if (w_hs) begin
      case (r_state)
        IDLE: begin
          if (i_tlp_sop) begin
            o_cpl_hdr_wr_en = 1'b1;
            case ({i_cpl_fmt_data_bit, i_tlp_eop})
              2'b01: w_received_nxt = 1'b1;
              2'b10: begin
                // Length of zero means the maximum 1024 DW payload
                w_remaining_nxt = {(i_cpl_length_field == '0), i_cpl_length_field};
                w_state_nxt     = DATA;
              end
              2'b00: begin
                w_malformed_nxt = 1'b1;
                w_state_nxt     = DROP;
              end
              default: w_malformed_nxt = 1'b1;
            endcase
          end else begin
            w_malformed_nxt = 1'b1;
          end
        end
        DATA: begin
          if (i_tlp_sop) begin
            w_malformed_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else begin
            o_cpl_data_wr_en    = 1'b1;
            o_cpl_data_valid_dw = (r_remaining >= BEAT_DW) ? {VALID_DATA_WIDTH{1'b1}}
                                                           : VALID_DATA_WIDTH'(r_remaining - 1'b1);
            w_remaining_nxt     = (r_remaining >= BEAT_DW) ? r_remaining - BEAT_DW : '0;
            if (w_last_beat && i_tlp_eop) begin
              w_received_nxt = 1'b1;
              w_state_nxt    = IDLE;
            end else if (i_tlp_eop) begin
              w_malformed_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else if (w_last_beat) begin
              w_malformed_nxt = 1'b1;
              w_state_nxt     = DROP;
            end
          end
        end
        DROP: begin
          if (i_tlp_eop) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_received  <= 1'b0;
      r_malformed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_received  <= w_received_nxt;
      r_malformed <= w_malformed_nxt;
    end
  end

  assign o_cpl_received  = r_received;
  assign o_cpl_malformed = r_malformed;

endmodule
